// File: rtl/mem_arbiter.sv
// mem_arbiter: two-way arbiter sharing one byte-wide single-port memory between IF and LS word accesses.
// Optional macro MEM_ARB_ALIGN_CHK_EN: misaligned requests skip the memory and ack with err.
module mem_arbiter #(
    parameter int ADDR_W = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_ack,
    output logic [31:0]       if_rdata,
    input  logic              ls_req,
    input  logic              ls_we,
    input  logic [ADDR_W-1:0] ls_addr,
    input  logic [31:0]       ls_wdata,
    output logic              ls_ack,
    output logic [31:0]       ls_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    input  logic [7:0]        mem_rdata,
    output logic              busy,
    output logic              err,
    output logic [1:0]        dbg_state
);

    // Handshake: a requester raises req with stable addr/we/wdata and holds it until its
    // one-cycle ack; req is sampled only in IDLE, so a request made while busy simply waits.
    typedef enum logic [1:0] {IDLE, XFER, CAPT, ACK} state_t;

    state_t            state, state_nxt;
    logic              last_grant;   // 0 = IF, 1 = LS
    logic              owner;
    logic              lat_we;
    logic              err_q;
    logic              cap_vld;
    logic [1:0]        beat;
    logic [ADDR_W-3:0] word_addr;
    logic [31:0]       wdata_q;
    logic [31:0]       word_q;

    logic              grant_any, grant_ls, misalign;
    logic [ADDR_W-1:0] sel_addr;

    assign grant_any = if_req | ls_req;
    assign grant_ls  = ls_req & (~if_req | ~last_grant);
    assign sel_addr  = grant_ls ? ls_addr : if_addr;

`ifdef MEM_ARB_ALIGN_CHK_EN
    assign misalign = (sel_addr[1:0] != 2'b00);
`else
    logic unused_addr_lo;
    assign unused_addr_lo = ^sel_addr[1:0];
    assign misalign       = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (grant_any) state_nxt = misalign ? ACK : XFER;
            XFER: if (beat == 2'd3) state_nxt = lat_we ? ACK : CAPT;
            CAPT: state_nxt = ACK;
            ACK:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= IDLE;
            last_grant <= 1'b0;
            owner      <= 1'b0;
            lat_we     <= 1'b0;
            err_q      <= 1'b0;
            cap_vld    <= 1'b0;
            beat       <= 2'd0;
            word_addr  <= '0;
            wdata_q    <= '0;
            word_q     <= '0;
            if_rdata   <= '0;
            ls_rdata   <= '0;
        end else begin
            state   <= state_nxt;
            // Read data returns one cycle after its beat; bytes arrive in big-endian order.
            cap_vld <= (state == XFER) && !lat_we;
            if (cap_vld) word_q <= {word_q[23:0], mem_rdata};
            case (state)
                IDLE: begin
                    if (grant_any) begin
                        owner      <= grant_ls;
                        last_grant <= grant_ls;
                        lat_we     <= grant_ls & ls_we;
                        wdata_q    <= ls_wdata;
                        word_addr  <= sel_addr[ADDR_W-1:2];
                        err_q      <= misalign;
                        beat       <= 2'd0;
                    end
                end
                XFER: beat <= beat + 2'd1;
                CAPT: begin
                    if (owner) ls_rdata <= {word_q[23:0], mem_rdata};
                    else       if_rdata <= {word_q[23:0], mem_rdata};
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        mem_en    = (state == XFER);
        mem_we    = (state == XFER) && lat_we;
        mem_addr  = (state == XFER) ? {word_addr, beat} : '0;
        mem_wdata = 8'h00;
        if (state == XFER && lat_we) begin
            case (beat)
                2'd0:    mem_wdata = wdata_q[31:24];
                2'd1:    mem_wdata = wdata_q[23:16];
                2'd2:    mem_wdata = wdata_q[15:8];
                default: mem_wdata = wdata_q[7:0];
            endcase
        end
    end

    assign if_ack    = (state == ACK) && !owner;
    assign ls_ack    = (state == ACK) && owner;
    assign err       = (state == ACK) && err_q;
    assign busy      = (state != IDLE);
    assign dbg_state = state;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: byte memory model, expected-access queue checked every cycle, directed tests.
// Builds with or without MEM_ARB_ALIGN_CHK_EN.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        if_req = 1'b0;
    logic [11:0] if_addr = '0;
    logic        if_ack;
    logic [31:0] if_rdata;
    logic        ls_req = 1'b0;
    logic        ls_we = 1'b0;
    logic [11:0] ls_addr = '0;
    logic [31:0] ls_wdata = '0;
    logic        ls_ack;
    logic [31:0] ls_rdata;
    logic        mem_en, mem_we;
    logic [11:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata = 8'h00;
    logic        busy, err;
    logic [1:0]  dbg_state;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    mem_arbiter #(.ADDR_W(12)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
        .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
        .ls_ack(ls_ack), .ls_rdata(ls_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .busy(busy), .err(err), .dbg_state(dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1);
    end

    // ---------------- memory bank model ----------------
    function automatic logic [7:0] init_byte(input int a);
        if (a >= 'h008 && a <= 'h00B) return 8'(8'h11 * (a - 7));
        if (a >= 'h010 && a <= 'h013) return 8'(8'hA0 + a - 'h010);
        if (a >= 'h020 && a <= 'h023) return 8'(8'hB0 + a - 'h020);
        if (a >= 'h200 && a <= 'h207) return 8'(8'hC0 + a - 'h200);
        if (a >= 'hFFC)               return 8'(8'h01 + a - 'hFFC);
        return 8'h00;
    endfunction

    logic [7:0] mem [4096];
    logic [7:0] ref_mem [4096];
    bit mem_ready = 1'b0;

    always @(posedge clk) begin
        if (!mem_ready) begin
            for (int i = 0; i < 4096; i++) mem[i] <= init_byte(i);
            mem_ready <= 1'b1;
        end else begin
            if (mem_en && mem_we) mem[mem_addr] <= mem_wdata;
            mem_rdata <= mem_en ? mem[mem_addr] : 8'h00;
        end
    end

    // ---------------- scoreboard ----------------
    typedef struct packed {
        logic        owner;   // 1 = LS
        logic        we;
        logic        err;
        logic [11:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
    } exp_t;
    localparam int EW = $bits(exp_t);
    logic [EW-1:0] exp_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
        end
    endtask

    // Accesses are pushed in the order the arbitration rule says they will be served,
    // so read data can be predicted from the reference memory at push time.
    task automatic push_exp(input logic owner, input logic we, input logic [11:0] addr,
                            input logic [31:0] wdata);
        exp_t e;
        int   base;
        e.owner = owner; e.we = we; e.addr = addr; e.wdata = wdata; e.rdata = '0;
`ifdef MEM_ARB_ALIGN_CHK_EN
        e.err = (addr[1:0] != 2'b00);
`else
        e.err = 1'b0;
`endif
        base = int'(addr) & 'hFFC;
        if (!e.err) begin
            e.rdata = {ref_mem[base], ref_mem[base+1], ref_mem[base+2], ref_mem[base+3]};
            if (we) for (int k = 0; k < 4; k++) ref_mem[base+k] = wdata[31-8*k -: 8];
        end
        exp_q.push_back(EW'(e));
    endtask

    // Per-cycle compare against the expected access at the head of the queue.
    int   beat_cnt = 0;
    int   first_en = 0;
    exp_t ce;
    always @(negedge clk) begin
        if (!rst) begin
            exp_q.delete();
            beat_cnt = 0;
        end else if (mem_ready) begin
            chk("ack_exclusive", 32'(if_ack & ls_ack), 32'd0);
            chk("en_implies_busy", 32'(mem_en & ~busy), 32'd0);
            if (mem_en) begin
                if (exp_q.size() == 0) chk("beat_unexpected", 32'd1, 32'd0);
                else begin
                    ce = exp_t'(exp_q[0]);
                    if (beat_cnt == 0) first_en = cyc;
                    chk("beat_addr", 32'(mem_addr), 32'((int'(ce.addr) & 'hFFC) + beat_cnt));
                    chk("beat_we", 32'(mem_we), 32'(ce.we));
                    if (ce.we) chk("beat_wdata", 32'(mem_wdata), 32'(ce.wdata[31-8*beat_cnt -: 8]));
                    beat_cnt++;
                end
            end
            if (if_ack || ls_ack) begin
                if (exp_q.size() == 0) chk("ack_unexpected", 32'd1, 32'd0);
                else begin
                    ce = exp_t'(exp_q.pop_front());
                    chk("ack_owner", 32'(ls_ack), 32'(ce.owner));
                    chk("ack_err", 32'(err), 32'(ce.err));
                    chk("ack_beats", 32'(beat_cnt), ce.err ? 32'd0 : 32'd4);
                    if (!ce.err) chk("ack_latency", 32'(cyc - first_en), ce.we ? 32'd4 : 32'd5);
                    if (!ce.err && !ce.we)
                        chk("ack_rdata", ce.owner ? ls_rdata : if_rdata, ce.rdata);
                end
                beat_cnt = 0;
            end else begin
                chk("err_without_ack", 32'(err), 32'd0);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0; if_req = 1'b0; ls_req = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_if_ack", 32'(if_ack), 32'd0);
        chk("rst_ls_ack", 32'(ls_ack), 32'd0);
        chk("rst_if_rdata", if_rdata, 32'd0);
        chk("rst_ls_rdata", ls_rdata, 32'd0);
        chk("rst_mem_en", 32'(mem_en), 32'd0);
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        chk("rst_mem_addr", 32'(mem_addr), 32'd0);
        chk("rst_mem_wdata", 32'(mem_wdata), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        rst = 1'b1;
    endtask

    // Lone LS access; lat is counted from the IDLE cycle in which req is first seen.
    task automatic ls_access(input logic we, input logic [11:0] addr, input logic [31:0] wd,
                             input int lat, input string name);
        int c0;
        bit got;
        push_exp(1'b1, we, addr, wd);
        @(negedge clk);
        ls_req = 1'b1; ls_we = we; ls_addr = addr; ls_wdata = wd;
        c0 = cyc; got = 1'b0;
        for (int c = 0; c < 40 && !got; c++) begin
            @(negedge clk);
            if (ls_ack) begin
                got = 1'b1;
                chk({name, "_latency"}, 32'(cyc - c0), 32'(lat));
            end
        end
        if (!got) chk({name, "_timeout"}, 32'd0, 32'd1);
        ls_req = 1'b0;
        @(negedge clk);
    endtask

    logic        op_ls_we   [4];
    logic [11:0] op_ls_addr [4];
    logic [31:0] op_ls_wd   [4];
    logic [11:0] op_if_addr [4];
    int          ls_ack_cyc [4];
    int          if_ack_cyc [4];
    logic        grant_log[$];

    // Both sides raise together; each drops req in its ack cycle and re-raises one cycle later.
    task automatic run_pair(input int n_ls, input int n_if, input string name);
        int li, ii;
        bit ls_rise, if_rise;
        li = 0; ii = 0; ls_rise = 1'b0; if_rise = 1'b0;
        grant_log.delete();
        @(negedge clk);
        if (n_ls > 0) begin
            ls_req = 1'b1; ls_we = op_ls_we[0]; ls_addr = op_ls_addr[0]; ls_wdata = op_ls_wd[0];
        end
        if (n_if > 0) begin
            if_req = 1'b1; if_addr = op_if_addr[0];
        end
        for (int c = 0; c < 300 && (li < n_ls || ii < n_if); c++) begin
            @(negedge clk);
            if (ls_rise) begin
                ls_rise = 1'b0; ls_req = 1'b1;
                ls_we = op_ls_we[li]; ls_addr = op_ls_addr[li]; ls_wdata = op_ls_wd[li];
            end else if (ls_ack) begin
                ls_req = 1'b0; ls_ack_cyc[li] = cyc; grant_log.push_back(1'b1);
                li++; ls_rise = (li < n_ls);
            end
            if (if_rise) begin
                if_rise = 1'b0; if_req = 1'b1; if_addr = op_if_addr[ii];
            end else if (if_ack) begin
                if_req = 1'b0; if_ack_cyc[ii] = cyc; grant_log.push_back(1'b0);
                ii++; if_rise = (ii < n_if);
            end
        end
        if (li < n_ls || ii < n_if) chk({name, "_timeout"}, 32'd0, 32'd1);
        ls_req = 1'b0; if_req = 1'b0;
        @(negedge clk);
    endtask

    // ---------------- directed tests ----------------
    initial begin
        for (int i = 0; i < 4096; i++) ref_mem[i] = init_byte(i);
        do_reset();

        // 1: LS write then read of one word
        ls_access(1'b1, 12'h004, 32'hDEADBEEF, 5, "t1_wr");
        chk("t1_mem_bytes", {mem[4], mem[5], mem[6], mem[7]}, 32'hDEADBEEF);
        ls_access(1'b0, 12'h004, 32'h0, 6, "t1_rd");
        chk("t1_ls_rdata", ls_rdata, 32'hDEADBEEF);

        // 2: simultaneous first requests after reset go LS first
        do_reset();
        op_ls_we[0] = 1'b0; op_ls_addr[0] = 12'h010; op_ls_wd[0] = '0;
        op_if_addr[0] = 12'h020;
        push_exp(1'b1, 1'b0, 12'h010, '0);
        push_exp(1'b0, 1'b0, 12'h020, '0);
        run_pair(1, 1, "t2");
        chk("t2_first_is_ls", 32'(grant_log[0]), 32'd1);
        chk("t2_if_after_ls", 32'(if_ack_cyc[0] - ls_ack_cyc[0]), 32'd7);
        chk("t2_ls_rdata", ls_rdata, 32'hA0A1A2A3);
        chk("t2_if_rdata", if_rdata, 32'hB0B1B2B3);

        // 3: continuous contention alternates LS, IF, LS, IF, LS, IF
        op_ls_we[0] = 1'b1; op_ls_addr[0] = 12'h100; op_ls_wd[0] = 32'h11223344;
        op_ls_we[1] = 1'b0; op_ls_addr[1] = 12'h100; op_ls_wd[1] = '0;
        op_ls_we[2] = 1'b1; op_ls_addr[2] = 12'h104; op_ls_wd[2] = 32'h55667788;
        op_if_addr[0] = 12'h200; op_if_addr[1] = 12'h204; op_if_addr[2] = 12'h104;
        push_exp(1'b1, 1'b1, 12'h100, 32'h11223344);
        push_exp(1'b0, 1'b0, 12'h200, '0);
        push_exp(1'b1, 1'b0, 12'h100, '0);
        push_exp(1'b0, 1'b0, 12'h204, '0);
        push_exp(1'b1, 1'b1, 12'h104, 32'h55667788);
        push_exp(1'b0, 1'b0, 12'h104, '0);
        run_pair(3, 3, "t3");
        chk("t3_grant_count", 32'(grant_log.size()), 32'd6);
        for (int i = 0; i < 6 && i < grant_log.size(); i++)
            chk("t3_alternation", 32'(grant_log[i]), 32'((i % 2) == 0));
        chk("t3_ls_rdata", ls_rdata, 32'h11223344);
        chk("t3_if_rdata", if_rdata, 32'h55667788);

        // 4: IF read of the top word
        op_if_addr[0] = 12'hFFC;
        push_exp(1'b0, 1'b0, 12'hFFC, '0);
        run_pair(0, 1, "t4");
        chk("t4_if_rdata", if_rdata, 32'h01020304);

        // 5: reset after two write beats aborts the write
        begin
            int c0;
            push_exp(1'b1, 1'b1, 12'h008, 32'hAABBCCDD);
            @(negedge clk);
            ls_req = 1'b1; ls_we = 1'b1; ls_addr = 12'h008; ls_wdata = 32'hAABBCCDD;
            c0 = cyc;
            repeat (2) @(negedge clk);
            chk("t5_second_beat", 32'(mem_addr), 32'h009);
            rst = 1'b0; ls_req = 1'b0;
            @(negedge clk);
            chk("t5_busy", 32'(busy), 32'd0);
            chk("t5_mem_en", 32'(mem_en), 32'd0);
            chk("t5_no_ack", 32'(ls_ack), 32'd0);
            rst = 1'b1;
            chk("t5_mem_bytes", {mem[8], mem[9], mem[10], mem[11]}, 32'hAABB3344);
            ref_mem[10] = 8'h33; ref_mem[11] = 8'h44;
        end
        ls_access(1'b0, 12'h008, 32'h0, 6, "t5_rd");
        chk("t5_ls_rdata", ls_rdata, 32'hAABB3344);

        // 6: misaligned LS read
`ifdef MEM_ARB_ALIGN_CHK_EN
        ls_access(1'b0, 12'h006, 32'h0, 1, "t6_rd");
        chk("t6_ls_rdata", ls_rdata, 32'hAABB3344);
`else
        ls_access(1'b0, 12'h006, 32'h0, 6, "t6_rd");
        chk("t6_ls_rdata", ls_rdata, 32'hDEADBEEF);
`endif
        chk("t6_queue_drained", 32'(exp_q.size()), 32'd0);

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
